// File: rtl/demux_1to2_b32.sv
// Registered 1-to-2 demultiplexer: one valid/ready producer routed by in_sel into
// two independent circular FIFOs, each with a 16-bit delivery counter.
module demux_1to2_b32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;

  // Handshake rule, both sides: a word moves on a rising edge where valid && ready.
  // in_ready never looks at in_valid; output valid never looks at output ready.

  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0]    head_q [2];
  logic [PW-1:0]    head_d [2];
  logic [PW-1:0]    tail_q [2];
  logic [PW-1:0]    tail_d [2];
  logic [OW-1:0]    occ_q  [2];
  logic [OW-1:0]    occ_d  [2];
  logic [15:0]      cnt_q  [2];
  logic [15:0]      cnt_d  [2];

  logic full      [2];
  logic out_valid [2];
  logic out_ready [2];
  logic push      [2];
  logic pop       [2];

  assign out_ready[0] = o0_ready;
  assign out_ready[1] = o1_ready;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      full[k]      = (occ_q[k] == OW'(DEPTH));
      out_valid[k] = (occ_q[k] != '0);
    end
  end

  // A full channel refuses even when its head pops this cycle: no ready pass-through.
  assign in_ready = !flush && (in_sel ? !full[1] : !full[0]);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      push[k]   = in_valid && in_ready && (in_sel == 1'(k));
      pop[k]    = !flush && out_valid[k] && out_ready[k];
      head_d[k] = head_q[k] + PW'(pop[k]);
      tail_d[k] = tail_q[k] + PW'(push[k]);
      cnt_d[k]  = cnt_q[k] + 16'(pop[k]);
      occ_d[k]  = occ_q[k];
      if (push[k] && !pop[k]) occ_d[k] = occ_q[k] + OW'(1);
      if (!push[k] && pop[k]) occ_d[k] = occ_q[k] - OW'(1);
      if (flush) begin
        head_d[k] = '0;
        tail_d[k] = '0;
        occ_d[k]  = '0;
        cnt_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        occ_q[k]  <= '0;
        cnt_q[k]  <= '0;
        for (int e = 0; e < DEPTH; e++) mem_q[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
        occ_q[k]  <= occ_d[k];
        cnt_q[k]  <= cnt_d[k];
        if (push[k]) mem_q[k][tail_q[k]] <= in_data;
      end
    end
  end

  // Outputs come straight from storage; data is stale whenever valid is low.
  assign o0_data  = mem_q[0][head_q[0]];
  assign o1_data  = mem_q[1][head_q[1]];
  assign o0_valid = out_valid[0];
  assign o1_valid = out_valid[1];
  assign cnt0     = cnt_q[0];
  assign cnt1     = cnt_q[1];

endmodule

// File: tb/tb_demux_1to2_b32.sv
// Directed bench for demux_1to2_b32: routing, backpressure, channel independence,
// counter wrap, flush and asynchronous reset.
module tb_demux_1to2_b32;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] o0_data;
  logic        o0_valid;
  logic        o0_ready;
  logic [31:0] o1_data;
  logic        o1_valid;
  logic        o1_ready;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  demux_1to2_b32 #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .o0_data(o0_data), .o0_valid(o0_valid), .o0_ready(o0_ready),
    .o1_data(o1_data), .o1_valid(o1_valid), .o1_ready(o1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    o0_ready = 1'b0; o1_ready = 1'b0;
    #2;
    chk_cnt++; if (o0_valid !== 1'b0) $display("FAIL reset_o0_valid got %b exp 0", o0_valid); else pass_cnt++;
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL reset_o1_valid got %b exp 0", o1_valid); else pass_cnt++;
    chk_cnt++; if (o0_data !== 32'h0) $display("FAIL reset_o0_data got %h exp 0", o0_data); else pass_cnt++;
    chk_cnt++; if (o1_data !== 32'h0) $display("FAIL reset_o1_data got %h exp 0", o1_data); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'h0) $display("FAIL reset_cnt0 got %h exp 0", cnt0); else pass_cnt++;
    chk_cnt++; if (cnt1 !== 16'h0) $display("FAIL reset_cnt1 got %h exp 0", cnt1); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step();
    chk_cnt++; if (o0_valid !== 1'b0) $display("FAIL idle_o0_valid got %b exp 0", o0_valid); else pass_cnt++;
  endtask

  task automatic test_route();
    o0_ready = 1'b1; o1_ready = 1'b1;
    in_data = 32'h11; in_sel = 1'b0; in_valid = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL route_in_ready got %b exp 1", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (o0_valid !== 1'b1) $display("FAIL route_o0_valid got %b exp 1", o0_valid); else pass_cnt++;
    chk_cnt++; if (o0_data !== 32'h11) $display("FAIL route_o0_data got %h exp 11", o0_data); else pass_cnt++;
    in_data = 32'h22; in_sel = 1'b1;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (o1_valid !== 1'b1) $display("FAIL route_o1_valid got %b exp 1", o1_valid); else pass_cnt++;
    chk_cnt++; if (o1_data !== 32'h22) $display("FAIL route_o1_data got %h exp 22", o1_data); else pass_cnt++;
    chk_cnt++; if (o0_valid !== 1'b0) $display("FAIL route_o0_drained got %b exp 0", o0_valid); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd1) $display("FAIL route_cnt0 got %0d exp 1", cnt0); else pass_cnt++;
    step();
    chk_cnt++; if (cnt1 !== 16'd1) $display("FAIL route_cnt1 got %0d exp 1", cnt1); else pass_cnt++;
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL route_o1_drained got %b exp 0", o1_valid); else pass_cnt++;
  endtask

  task automatic test_full();
    do_flush();
    o0_ready = 1'b0;
    in_sel = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_data = 32'hC;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (o0_data !== 32'hA) $display("FAIL full_head got %h exp A", o0_data); else pass_cnt++;
    o0_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_no_passthru got %b exp 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (o0_data !== 32'hB) $display("FAIL full_pop1 got %h exp B", o0_data); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_reopen got %b exp 1", in_ready); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd1) $display("FAIL full_cnt_a got %0d exp 1", cnt0); else pass_cnt++;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (o0_data !== 32'hC) $display("FAIL full_pop2 got %h exp C", o0_data); else pass_cnt++;
    chk_cnt++; if (o0_valid !== 1'b1) $display("FAIL full_valid_c got %b exp 1", o0_valid); else pass_cnt++;
    step();
    chk_cnt++; if (o0_valid !== 1'b0) $display("FAIL full_empty got %b exp 0", o0_valid); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd3) $display("FAIL full_cnt0 got %0d exp 3", cnt0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_flush();
    o0_ready = 1'b0; o1_ready = 1'b1;
    in_sel = 1'b0; in_valid = 1'b1;
    in_data = 32'hA0; step();
    in_data = 32'hA1; step();
    in_sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h100 + i;
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); else pass_cnt++;
      step();
      chk_cnt++; if (o1_data !== 32'h100 + i) $display("FAIL b2b_data[%0d] got %h exp %h", i, o1_data, 32'h100 + i); else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    chk_cnt++; if (cnt1 !== 16'd16) $display("FAIL b2b_cnt1 got %0d exp 16", cnt1); else pass_cnt++;
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL b2b_o1_empty got %b exp 0", o1_valid); else pass_cnt++;
    chk_cnt++; if (o0_data !== 32'hA0) $display("FAIL b2b_ch0_head got %h exp A0", o0_data); else pass_cnt++;
    chk_cnt++; if (o0_valid !== 1'b1) $display("FAIL b2b_ch0_valid got %b exp 1", o0_valid); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd0) $display("FAIL b2b_cnt0 got %0d exp 0", cnt0); else pass_cnt++;
  endtask

  task automatic test_cnt_wrap();
    do_flush();
    o0_ready = 1'b1; o1_ready = 1'b0;
    in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk_cnt++; if (cnt0 !== 16'hFFFF) $display("FAIL wrap_pre got %h exp FFFF", cnt0); else pass_cnt++;
    in_data = 32'hDEAD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (o0_data !== 32'hDEAD) $display("FAIL wrap_last_data got %h exp DEAD", o0_data); else pass_cnt++;
    step();
    chk_cnt++; if (cnt0 !== 16'h0000) $display("FAIL wrap_cnt0 got %h exp 0000", cnt0); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_flush();
    o0_ready = 1'b1; o1_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0; in_data = 32'h30; step();
    in_sel = 1'b1; in_data = 32'h31; step();
    in_data = 32'h32; step();
    in_data = 32'h33;
    flush = 1'b1; o1_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd1) $display("FAIL flush_pre_cnt0 got %0d exp 1", cnt0); else pass_cnt++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL flush_o1_valid got %b exp 0", o1_valid); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd0) $display("FAIL flush_cnt0 got %0d exp 0", cnt0); else pass_cnt++;
    chk_cnt++; if (cnt1 !== 16'd0) $display("FAIL flush_cnt1 got %0d exp 0", cnt1); else pass_cnt++;
    step();
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL flush_no_late got %b exp 0", o1_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    o0_ready = 1'b1; o1_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0; in_data = 32'h40; step();
    in_sel = 1'b1; in_data = 32'h41; step();
    in_data = 32'h42; step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL rstmid_o1_valid got %b exp 0", o1_valid); else pass_cnt++;
    chk_cnt++; if (o1_data !== 32'h0) $display("FAIL rstmid_o1_data got %h exp 0", o1_data); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 16'd0) $display("FAIL rstmid_cnt0 got %0d exp 0", cnt0); else pass_cnt++;
    step();
    rst_n = 1'b1; o1_ready = 1'b1;
    step(); step();
    chk_cnt++; if (o1_valid !== 1'b0) $display("FAIL rstmid_after got %b exp 0", o1_valid); else pass_cnt++;
    chk_cnt++; if (cnt1 !== 16'd0) $display("FAIL rstmid_cnt1 got %0d exp 0", cnt1); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b exp 1", in_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_route();
    test_full();
    test_back_to_back();
    test_cnt_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/demux_1to2_b32.md
# demux_1to2_b32

Registered 1-to-2 demultiplexer for 32-bit operand/result words in the calculator datapath. It accepts one word per cycle on a valid/ready input channel and routes it, per a select bit, into one of two independent buffered output channels. It performs the inverse of the datapath's 2-to-1 operand select: one producer, two consumers (select 0 to channel 0, select 1 to channel 1). It also keeps per-channel delivery counters for debug and display.

## Interface
Parameters:
- WIDTH, 32, data word width
- DEPTH, 2, per-channel buffer entries; power of two, 2..8

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous: empties both buffers and clears both counters
- in_data  in  WIDTH  word to route
- in_sel  in  1  destination: 0 to channel 0, 1 to channel 1; sampled with in_data
- in_valid  in  1  in_data/in_sel valid
- in_ready  out  1  block can accept the presented word
- o0_data  out  WIDTH  head word of channel 0 buffer
- o0_valid  out  1  channel 0 buffer non-empty
- o0_ready  in  1  channel 0 sink accepts
- o1_data  out  WIDTH  head word of channel 1 buffer
- o1_valid  out  1  channel 1 buffer non-empty
- o1_ready  in  1  channel 1 sink accepts
- cnt0  out  16  words delivered on channel 0
- cnt1  out  16  words delivered on channel 1

## Operation
- Per channel: a circular FIFO of DEPTH entries with head pointer, tail pointer and occupancy counter. The occupancy counter is one bit wider than the pointers, so full and empty are distinguishable.
- in_ready = !flush && (in_sel ? !full1 : !full0). It depends combinationally on in_sel and flush only, never on in_valid.
- Input transfer: in_valid && in_ready at a rising edge. in_data is written at the selected channel's tail; tail and occupancy advance.
- Output transfer on channel k: ok_valid && ok_ready. Head advances, occupancy decrements, cntk increments.
- Simultaneous push and pop on one channel: occupancy unchanged, both pointers advance.
- A full buffer never accepts, even if popped in the same cycle. There is no ready pass-through.
- Channels are independent. A stalled sink on one channel never blocks traffic routed to the other.
- Word order is preserved within each channel. No ordering relation exists across channels.
- ok_data is driven from the head register/array entry. No combinational path runs from in_data to ok_data.
- Pointers wrap modulo DEPTH.
- cntk wraps from 0xFFFF to 0x0000.
- flush: in the cycle flush is high, no input is accepted (in_ready=0) and any output handshake is ignored (no count). At that edge both occupancies, pointers and counters go to 0.
- ok_data when ok_valid=0: holds the stale head entry; consumers must not sample it.

## Timing
- Reset values (rst_n low, asynchronous):
  - o0_valid=o1_valid=0
  - o0_data=o1_data=0 (storage cleared)
  - cnt0=cnt1=0
  - in_ready=1 (given flush=0)
- Latency: a word accepted at edge N has ok_valid=1 and ok_data equal to the word from just after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle sustained on a channel whose sink holds ready=1.
- Buffer full: in_ready falls after the edge that fills it. It rises again after the first pop edge.
- Reset asserted mid-transfer: all buffered words are discarded immediately. Nothing is delivered after release.

## Test plan
- Reset then idle -> o0_valid=o1_valid=0, cnt0=cnt1=0, in_ready=1.
- Send 0x00000011 (sel=0) then 0x00000022 (sel=1), both sinks ready -> o0 shows 0x11 one cycle after its accept, o1 shows 0x22 one cycle after its accept, cnt0=cnt1=1.
- Hold o0_ready=0; send three sel=0 words A, B, C -> A and B accepted, in_ready=0 on C. Raise o0_ready -> A, B, C delivered in order, cnt0=3.
- With o0_ready=0 and channel 0 full, stream 0x100..0x10F on sel=1 -> all 16 delivered on o1, cnt1=16, channel 0 contents unchanged.
- Preload cnt0 to 0xFFFF deliveries, then deliver one more -> cnt0=0x0000.
- Two words buffered on channel 1, assert flush with in_valid=1 -> word not accepted, o1_valid=0 next cycle, cnt0=cnt1=0. Repeat with rst_n pulsed low mid-stream -> same empty state.
